counter_timer_low: RTL and testbench

COUNTER_TIMER_LOW -- requirements
Module: counter_timer_low

---
 rtl/counter_timer_low.sv | 218 +++++++++++++++++++++
 tb/tb_counter_timer_low.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_low.sv
// ============================================================================
// counter_timer_low
// Low 32-bit word of a chainable counter/timer. Counts up or down between 0
// and value_reset, either once (oneshot) or continuously. When chained, it
// acts as the low word of a 64-bit counter. It produces a wrap strobe for the
// high word and uses the high word's stop_out as a qualifier for its own
// terminal condition.
//
// Optional feature: define COUNTER_TIMER_LOW_IRQ_EN to implement irq_ena
// (cfg bit4) and the irq_out pulse. In the default build, cfg bit4 reads 0
// and irq_out is tied to 0.
//
// Ports:
//   clkin        in   1   clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   reg_cfg_we   in   1   config write strobe
//   reg_cfg_di   in  32   config write data
//                         (bit0 enable, bit1 oneshot, bit2 updown, bit3 chain,
//                          bit4 irq_ena)
//   reg_cfg_do   out 32   config readback
//   reg_val_we   in   4   byte enables for value_reset
//   reg_val_di   in  32   value_reset write data
//   reg_val_do   out 32   value_reset readback
//   reg_dat_we   in   4   byte enables for value_cur
//   reg_dat_di   in  32   value_cur write data
//   reg_dat_do   out 32   value_cur readback
//   enable_in    in   1   enable from the high-word counter
//   stop_in      in   1   stop_out of the high-word counter
//   strobe       out  1   wrap strobe to the high word (combinational)
//   is_offset    out  1   high-word compare-offset select (combinational)
//   enable_out   out  1   config enable bit
//   stop_out     out  1   terminal-count flag (registered)
//   irq_out      out  1   one-cycle interrupt pulse (registered)
// ============================================================================
module counter_timer_low (
    input  logic        clkin,
    input  logic        resetn,
    input  logic        reg_cfg_we,
    input  logic [31:0] reg_cfg_di,
    output logic [31:0] reg_cfg_do,
    input  logic [3:0]  reg_val_we,
    input  logic [31:0] reg_val_di,
    output logic [31:0] reg_val_do,
    input  logic [3:0]  reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    input  logic        enable_in,
    input  logic        stop_in,
    output logic        strobe,
    output logic        is_offset,
    output logic        enable_out,
    output logic        stop_out,
    output logic        irq_out
);

    // Merge the enabled bytes of new_v into old_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic        enable_r;
    logic        oneshot_r;
    logic        updown_r;
    logic        chain_r;
    logic [31:0] value_reset_r;
    logic [31:0] value_cur_r;
    logic        lastenable_r;
    logic        stop_r;

    logic        loc_enable_s;
    logic        dat_write_s;
    logic        terminal_s;
    logic        wrap_s;
    logic        strobe_s;
    logic        is_offset_s;
    logic [31:0] cur_next_s;
    logic        stop_next_s;
    logic        irq_ena_s;
    logic        unused_cfg_s;

`ifdef COUNTER_TIMER_LOW_IRQ_EN
    logic        irq_ena_r;
    logic        stop_d_r;
    logic        irq_r;
    logic        irq_next_s;

    assign irq_ena_s    = irq_ena_r;
    assign unused_cfg_s = ^reg_cfg_di[31:5];
`else
    assign irq_ena_s    = 1'b0;
    assign unused_cfg_s = ^reg_cfg_di[31:4];
`endif

    // Local enable, terminal detection, wrap strobe and offset select.
    always_comb begin
        if (chain_r) begin
            loc_enable_s = enable_r & enable_in;
        end else begin
            loc_enable_s = enable_r;
        end
        dat_write_s = |reg_dat_we;
        // When chained, the limit counts as terminal only if the high word has
        // also reached its own limit.
        if (updown_r) begin
            terminal_s = (value_cur_r == value_reset_r) & (~chain_r | stop_in);
            wrap_s     = (value_cur_r == 32'hFFFF_FFFF);
        end else begin
            terminal_s = (value_cur_r == 32'h0000_0000) & (~chain_r | stop_in);
            wrap_s     = (value_cur_r == 32'h0000_0000);
        end
        strobe_s    = chain_r & loc_enable_s & lastenable_r & ~dat_write_s
                      & ~terminal_s & wrap_s;
        is_offset_s = chain_r & updown_r & (value_reset_r == 32'hFFFF_FFFF);
    end

    // Next count value and stop flag. A data write has priority and freezes stop.
    always_comb begin
        cur_next_s  = value_cur_r;
        stop_next_s = stop_r;
        if (dat_write_s) begin
            cur_next_s  = byte_merge(value_cur_r, reg_dat_di, reg_dat_we);
            stop_next_s = stop_r;
        end else if (!loc_enable_s) begin
            cur_next_s  = value_cur_r;
            stop_next_s = 1'b0;
        end else if (!lastenable_r) begin
            // The first enabled cycle restarts from the count origin.
            cur_next_s  = updown_r ? 32'h0000_0000 : value_reset_r;
            stop_next_s = 1'b0;
        end else if (terminal_s) begin
            stop_next_s = 1'b1;
            if (oneshot_r) begin
                cur_next_s = value_cur_r;
            end else begin
                cur_next_s = updown_r ? 32'h0000_0000 : value_reset_r;
            end
        end else begin
            cur_next_s  = updown_r ? (value_cur_r + 32'd1) : (value_cur_r - 32'd1);
            stop_next_s = 1'b0;
        end
    end

    // Configuration, reload value, live count and stop flag registers.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            enable_r      <= 1'b0;
            oneshot_r     <= 1'b0;
            updown_r      <= 1'b0;
            chain_r       <= 1'b0;
            value_reset_r <= 32'h0000_0000;
            value_cur_r   <= 32'h0000_0000;
            lastenable_r  <= 1'b0;
            stop_r        <= 1'b0;
        end else begin
            if (reg_cfg_we) begin
                enable_r  <= reg_cfg_di[0];
                oneshot_r <= reg_cfg_di[1];
                updown_r  <= reg_cfg_di[2];
                chain_r   <= reg_cfg_di[3];
            end
            value_reset_r <= byte_merge(value_reset_r, reg_val_di, reg_val_we);
            value_cur_r   <= cur_next_s;
            lastenable_r  <= loc_enable_s;
            stop_r        <= stop_next_s;
        end
    end

`ifdef COUNTER_TIMER_LOW_IRQ_EN
    // Interrupt request: detect a rising edge of stop one cycle late. No
    // pulse is generated during a data write.
    always_comb begin
        if (dat_write_s) begin
            irq_next_s = 1'b0;
        end else begin
            irq_next_s = irq_ena_r & loc_enable_s & stop_r & ~stop_d_r;
        end
    end

    // Interrupt enable, delayed stop and interrupt pulse registers.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            irq_ena_r <= 1'b0;
            stop_d_r  <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (reg_cfg_we) begin
                irq_ena_r <= reg_cfg_di[4];
            end
            stop_d_r <= stop_r;
            irq_r    <= irq_next_s;
        end
    end

    assign irq_out = irq_r;
`else
    assign irq_out = 1'b0;
`endif

    assign reg_cfg_do = {27'd0, irq_ena_s, chain_r, updown_r, oneshot_r, enable_r};
    assign reg_val_do = value_reset_r;
    assign reg_dat_do = value_cur_r;
    assign strobe     = strobe_s;
    assign is_offset  = is_offset_s;
    assign enable_out = enable_r;
    assign stop_out   = stop_r;

endmodule

// File: tb/tb_counter_timer_low.sv
// Directed scoreboard bench for counter_timer_low. Expected per-cycle outputs
// are queued as stimulus is driven and compared after each rising edge.
module tb_counter_timer_low;

`ifdef COUNTER_TIMER_LOW_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    logic        clkin = 1'b0;
    logic        resetn;
    logic        reg_cfg_we;
    logic [31:0] reg_cfg_di;
    logic [31:0] reg_cfg_do;
    logic [3:0]  reg_val_we;
    logic [31:0] reg_val_di;
    logic [31:0] reg_val_do;
    logic [3:0]  reg_dat_we;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        enable_in;
    logic        stop_in;
    logic        strobe;
    logic        is_offset;
    logic        enable_out;
    logic        stop_out;
    logic        irq_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] cur;
        logic        stop;
        logic        strb;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    always #5 clkin = ~clkin;

    counter_timer_low dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .reg_cfg_we (reg_cfg_we),
        .reg_cfg_di (reg_cfg_di),
        .reg_cfg_do (reg_cfg_do),
        .reg_val_we (reg_val_we),
        .reg_val_di (reg_val_di),
        .reg_val_do (reg_val_do),
        .reg_dat_we (reg_dat_we),
        .reg_dat_di (reg_dat_di),
        .reg_dat_do (reg_dat_do),
        .enable_in  (enable_in),
        .stop_in    (stop_in),
        .strobe     (strobe),
        .is_offset  (is_offset),
        .enable_out (enable_out),
        .stop_out   (stop_out),
        .irq_out    (irq_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] cur, input logic stop,
                        input logic strb, input logic irq);
        exp_t e;
        e.tag  = tag;
        e.cur  = cur;
        e.stop = stop;
        e.strb = strb;
        e.irq  = irq;
        exp_q.push_back(e);
    endtask

    task automatic tick_pop();
        exp_t e;
        tick();
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_cur"},    reg_dat_do,       e.cur);
            chk({e.tag, "_stop"},   {31'd0, stop_out}, {31'd0, e.stop});
            chk({e.tag, "_strobe"}, {31'd0, strobe},   {31'd0, e.strb});
            chk({e.tag, "_irq"},    {31'd0, irq_out},  {31'd0, e.irq});
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            tick_pop();
        end
    endtask

    task automatic wr_cfg(input logic [31:0] d);
        reg_cfg_we = 1'b1;
        reg_cfg_di = d;
        tick();
        reg_cfg_we = 1'b0;
        #1;
    endtask

    task automatic wr_val(input logic [31:0] d);
        reg_val_we = 4'hF;
        reg_val_di = d;
        tick();
        reg_val_we = 4'h0;
        #1;
    endtask

    task automatic wr_dat(input logic [3:0] be, input logic [31:0] d);
        reg_dat_we = be;
        reg_dat_di = d;
        tick();
        reg_dat_we = 4'h0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn     = 1'b0;
        reg_cfg_we = 1'b0;
        reg_cfg_di = 32'd0;
        reg_val_we = 4'h0;
        reg_val_di = 32'd0;
        reg_dat_we = 4'h0;
        reg_dat_di = 32'd0;
        enable_in  = 1'b0;
        stop_in    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_cfg",    reg_cfg_do, 32'd0);
        chk("rst_val",    reg_val_do, 32'd0);
        chk("rst_dat",    reg_dat_do, 32'd0);
        chk("rst_stop",   {31'd0, stop_out},   32'd0);
        chk("rst_irq",    {31'd0, irq_out},    32'd0);
        chk("rst_strobe", {31'd0, strobe},     32'd0);
        chk("rst_offset", {31'd0, is_offset},  32'd0);
        chk("rst_en",     {31'd0, enable_out}, 32'd0);
        resetn = 1'b1;
        tick();

        // Standalone up, oneshot, limit 5, irq enabled; unused cfg bits read 0
        wr_val(32'd5);
        wr_cfg(32'hFFFF_FF17);
        chk("up_cfg_rb", reg_cfg_do, IRQ_BUILT ? 32'h0000_0017 : 32'h0000_0007);
        chk("up_en_out", {31'd0, enable_out}, 32'd1);
        for (int i = 0; i <= 5; i++) begin
            push("up_os", 32'(i), 1'b0, 1'b0, 1'b0);
        end
        push("up_os_stop", 32'd5, 1'b1, 1'b0, 1'b0);
        push("up_os_irq",  32'd5, 1'b1, 1'b0, IRQ_BUILT);
        push("up_os_hold", 32'd5, 1'b1, 1'b0, 1'b0);
        push("up_os_hold", 32'd5, 1'b1, 1'b0, 1'b0);
        drain();
        // Disabling: stop clears on the cycle after enable drops
        wr_cfg(32'h0);
        chk("dis_en_out", {31'd0, enable_out}, 32'd0);
        push("dis", 32'd5, 1'b0, 1'b0, 1'b0);
        drain();

        // Standalone down, continuous, limit 3
        wr_val(32'd3);
        wr_cfg(32'h01);
        push("dn", 32'd3, 1'b0, 1'b0, 1'b0);
        push("dn", 32'd2, 1'b0, 1'b0, 1'b0);
        push("dn", 32'd1, 1'b0, 1'b0, 1'b0);
        push("dn", 32'd0, 1'b0, 1'b0, 1'b0);
        push("dn_rl", 32'd3, 1'b1, 1'b0, 1'b0);
        push("dn", 32'd2, 1'b0, 1'b0, 1'b0);
        push("dn", 32'd1, 1'b0, 1'b0, 1'b0);
        push("dn", 32'd0, 1'b0, 1'b0, 1'b0);
        push("dn_rl", 32'd3, 1'b1, 1'b0, 1'b0);
        push("dn", 32'd2, 1'b0, 1'b0, 1'b0);
        drain();
        wr_cfg(32'h0);
        tick();

        // Chained up across the 32-bit wrap
        enable_in = 1'b1;
        stop_in   = 1'b0;
        wr_val(32'hFFFF_FFFF);
        wr_cfg(32'h0D);
        chk("ch_offset", {31'd0, is_offset}, 32'd1);
        push("ch_load", 32'd0, 1'b0, 1'b0, 1'b0);
        drain();
        wr_dat(4'hF, 32'hFFFF_FFFE);
        chk("ch_pre_cur", reg_dat_do, 32'hFFFF_FFFE);
        chk("ch_pre_strobe", {31'd0, strobe}, 32'd0);
        push("ch_wrap", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        push("ch_zero", 32'd0, 1'b0, 1'b0, 1'b0);
        push("ch_one",  32'd1, 1'b0, 1'b0, 1'b0);
        drain();
        // High word withdraws enable: hold, then restart from 0
        enable_in = 1'b0;
        push("ch_hold", 32'd1, 1'b0, 1'b0, 1'b0);
        drain();
        enable_in = 1'b1;
        push("ch_restart", 32'd0, 1'b0, 1'b0, 1'b0);
        drain();

        // Chained up oneshot limit 10 with stop_in held, then released
        wr_cfg(32'h0);
        wr_val(32'd10);
        stop_in = 1'b1;
        wr_cfg(32'h0F);
        chk("co_offset", {31'd0, is_offset}, 32'd0);
        for (int i = 0; i <= 10; i++) begin
            push("co", 32'(i), 1'b0, 1'b0, 1'b0);
        end
        push("co_stop", 32'd10, 1'b1, 1'b0, 1'b0);
        push("co_stop", 32'd10, 1'b1, 1'b0, 1'b0);
        drain();
        stop_in = 1'b0;
        push("co_past", 32'd11, 1'b0, 1'b0, 1'b0);
        push("co_past", 32'd12, 1'b0, 1'b0, 1'b0);
        drain();

        // Byte write during counting suppresses increment and strobe
        wr_dat(4'hF, 32'hFFFF_FFFF);
        chk("bw_strobe_pre", {31'd0, strobe}, 32'd1);
        reg_dat_we = 4'b0001;
        reg_dat_di = 32'h0000_00AA;
        #1;
        chk("bw_strobe_wr", {31'd0, strobe}, 32'd0);
        push("bw_byte", 32'hFFFF_FFAA, 1'b0, 1'b0, 1'b0);
        tick_pop();
        reg_dat_we = 4'h0;
        push("bw_next", 32'hFFFF_FFAB, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset mid-count with stop_out and is_offset high
        wr_cfg(32'h0);
        wr_val(32'hFFFF_FFFF);
        stop_in   = 1'b1;
        enable_in = 1'b1;
        wr_cfg(32'h0F);
        push("rm_load", 32'd0, 1'b0, 1'b0, 1'b0);
        drain();
        wr_dat(4'hF, 32'hFFFF_FFFE);
        push("rm_term", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        push("rm_stop", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drain();
        chk("rm_offset_pre", {31'd0, is_offset}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rm_stop",   {31'd0, stop_out},   32'd0);
        chk("rm_irq",    {31'd0, irq_out},    32'd0);
        chk("rm_strobe", {31'd0, strobe},     32'd0);
        chk("rm_offset", {31'd0, is_offset},  32'd0);
        chk("rm_en",     {31'd0, enable_out}, 32'd0);
        chk("rm_cfg",    reg_cfg_do, 32'd0);
        chk("rm_val",    reg_val_do, 32'd0);
        chk("rm_dat",    reg_dat_do, 32'd0);
        #1;
        resetn = 1'b1;
        tick();
        tick();
        chk("post_idle_cur",  reg_dat_do, 32'd0);
        chk("post_idle_stop", {31'd0, stop_out}, 32'd0);
        chk("post_idle_en",   {31'd0, enable_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
